sb_resp: RTL
============

// Module: sb_resp
// PURPOSE
// - System-bus responder for the CoNM core: serves instruction fetch and data load/store in one unified word-organised RAM.
// - Takes the core's fetch address and load/store request (enables, address, size mask, signedness, write data).
// - Returns the fetched instruction and the load data (same cycle, combinational) to the core.
// - Stores are registered into a 1-entry write buffer and committed to RAM the following cycle; loads and fetches forward from it.
// PARAMETERS
// - MEM_WORDS   4096  RAM depth in 32-bit words; must be a power of 2; IDX_W = $clog2(MEM_WORDS)
// - BASE_ADDR   32'h0 byte address of RAM word 0
// - ERR_CNT_W   8     width of the saturating fault counter
// PORTS
// - clk          in   1   core clock, all state on posedge
// - rst          in   1   asynchronous, active-low reset (rst==0 resets)
// - imem_addr    in   32  fetch byte address (word aligned)
// - imem_inst    out  32  fetched instruction
// - sb_re        in   1   load request
// - sb_we        in   1   store request
// - sb_addr      in   32  load/store byte address
// - sb_byte_mask in   4   size: 4'b0001 byte, 4'b0011 half, 4'b1111 word; other codes are faults
// - sb_un_sign   in   1   1 = zero-extend load, 0 = sign-extend
// - sb_wdata     in   32  store data, LSB-justified
// - sb_rdata     out  32  load data to register file
// - sb_err       out  1   registered one-cycle fault pulse
// - sb_err_cnt   out  ERR_CNT_W  saturating fault count
// BEHAVIOUR
// - Reset values: wb_valid=0, sb_err=0, sb_err_cnt=0, mmio regs=0. RAM contents are not reset.
//   imem_inst and sb_rdata are combinational; they reflect RAM state and are not reset values.
// - Index and offset: idx = (addr-BASE_ADDR)>>2, off = addr[1:0].
//   A request is in range iff (addr-BASE_ADDR) < MEM_WORDS*4.
// - Fault: in-range check fails, bad mask, half with off[0]=1, word with off!=0, or re&&we.
//   On a fault: no RAM/buffer update; sb_rdata=0; sb_err=1 on the next cycle; sb_err_cnt+1 (saturates at all-ones).
//   An out-of-range fetch returns imem_inst=32'h0000_0013 (NOP) and counts no fault.
// - Store (we, no fault): at the clock edge, capture wb_idx=idx, wb_lanes=mask<<off, wb_data=wdata<<(8*off); set wb_valid=1.
// - Commit: while wb_valid, at each edge write wb_data lanes of wb_lanes into RAM[wb_idx].
//   Clear wb_valid the same edge unless a new store is captured.
//   Back-to-back stores: the edge commits the old entry and captures the new one. Throughput is 1 store/cycle; the core never stalls.
// - Forwarding: any read of word w with wb_valid && wb_idx==w merges the wb_data lanes over the RAM word. This applies to both the load path and the fetch path.
// - Load: word = forwarded read; shift right by 8*off; keep mask bytes; extend per sb_un_sign. Word loads ignore un_sign.
// - Idle: re=we=0 gives sb_rdata=0.
// - Reset mid-operation: a pending buffer entry is discarded, not committed.
// CONFIGURATION
// - Macro SB_RESP_MMIO_EN adds a tohost register at byte address 32'h1000_0000 (outside the RAM range).
//   Adds ports mmio_tohost out 32 and mmio_valid out 1.
//   An aligned word store to that address latches wdata into mmio_tohost and pulses mmio_valid for 1 cycle; no fault is raised.
//   A load from that address returns mmio_tohost. Any non-word access there is a fault.
// - Without the macro: the address is ordinary out-of-range, so it faults; the ports are absent.
// STRUCTURE
// - defines.v gets: SB_SZ_B/SB_SZ_H/SB_SZ_W mask codes, SB_MMIO_TOHOST address, NOP constant.
//   Reuse existing `DATA_WIDTH/`BYTE_SEL/`MEM_ADDR_WIDTH.
// - One sub-module, sb_ram: MEM_WORDS x 32.
//   Two asynchronous read ports (fetch, data) and one synchronous write port with 4-bit lane enable.
//   Forwarding, alignment and extension logic live in sb_resp.
// TESTING
// - Store word 0xDEADBEEF to 0x10, load word 0x10 next cycle -> sb_rdata=0xDEADBEEF via forwarding. Two cycles later, same result from RAM.
// - Store byte 0x80 to 0x13, then load byte signed -> 0xFFFFFF80. Load byte unsigned -> 0x00000080. Load word 0x10 -> 0x80ADBEEF.
// - Store half to 0x11 -> no write, sb_err=1 one cycle later, sb_err_cnt=1. Repeat 300 faults -> sb_err_cnt stays 0xFF.
// - Back-to-back stores 0x1111_1111 @0x20 then 0x2222_2222 @0x24, with fetch of 0x24 in the second cycle after.
//   -> imem_inst=0x2222_2222; both words are correct in RAM afterwards.
// - Store to 0x30, then assert rst=0 before the next edge -> RAM[0x30>>2] unchanged; wb_valid=0, sb_err_cnt=0.
// - MMIO_EN: store 0x1 to 0x1000_0000 -> mmio_tohost=1, mmio_valid one-cycle pulse, sb_err=0. Without the macro -> sb_err=1.

Source files
------------

// File: rtl/sb_resp_pkg.sv
// Shared constants and helpers for the sb_resp system-bus responder.
// Size mask codes, the tohost address and lane/extension helpers.
package sb_resp_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int BYTE_SEL       = 4;

    localparam logic [3:0]  SB_SZ_B        = 4'b0001;
    localparam logic [3:0]  SB_SZ_H        = 4'b0011;
    localparam logic [3:0]  SB_SZ_W        = 4'b1111;
    localparam logic [31:0] SB_MMIO_TOHOST = 32'h1000_0000;
    localparam logic [31:0] SB_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_LOAD,
        ACC_STORE,
        ACC_BAD
    } sb_acc_e;

    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] upd,
        input logic [BYTE_SEL-1:0]   lanes
    );
        logic [DATA_WIDTH-1:0] r;
        r = base;
        for (int b = 0; b < BYTE_SEL; b++) begin
            if (lanes[b]) begin
                r[8*b +: 8] = upd[8*b +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_ext(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [BYTE_SEL-1:0]   mask,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] r;
        sh = word >> {off, 3'b000};
        r  = sh;
        if (mask == SB_SZ_B) begin
            r = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (mask == SB_SZ_H) begin
            r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_ram.sv
// Unified word RAM: two asynchronous read ports and one
// synchronous lane-enabled write port. Contents are not reset.
module sb_ram #(
    parameter int MEM_WORDS = 4096,
    parameter int IDX_W     = $clog2(MEM_WORDS)
)(
    input  logic             clk,
    input  logic [IDX_W-1:0] i_raddr_a,
    output logic [31:0]      o_rdata_a,
    input  logic [IDX_W-1:0] i_raddr_b,
    output logic [31:0]      o_rdata_b,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [3:0]       i_wlanes,
    input  logic [31:0]      i_wdata
);

    logic [31:0] r_mem [MEM_WORDS];

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wlanes[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/sb_resp.sv
// System-bus responder: unified fetch/load/store RAM with a 1-entry write buffer.
// Optional tohost register enabled by SB_RESP_MMIO_EN.
module sb_resp
    import sb_resp_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          ERR_CNT_W = 8
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          imem_addr,
    output logic [31:0]          imem_inst,
    input  logic                 sb_re,
    input  logic                 sb_we,
    input  logic [31:0]          sb_addr,
    input  logic [3:0]           sb_byte_mask,
    input  logic                 sb_un_sign,
    input  logic [31:0]          sb_wdata,
    output logic [31:0]          sb_rdata,
    output logic                 sb_err,
    output logic [ERR_CNT_W-1:0] sb_err_cnt
`ifdef SB_RESP_MMIO_EN
    ,
    output logic [31:0]          mmio_tohost,
    output logic                 mmio_valid
`endif
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    logic                 r_wb_valid;
    logic [IDX_W-1:0]     r_wb_idx;
    logic [3:0]           r_wb_lanes;
    logic [31:0]          r_wb_data;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [31:0]      w_drel;
    logic [31:0]      w_irel;
    logic             w_din;
    logic             w_iin;
    logic [IDX_W-1:0] w_didx;
    logic [IDX_W-1:0] w_iidx;
    logic [1:0]       w_off;
    logic             w_mask_ok;
    logic             w_mmio_ok;
    logic             w_act;
    logic             w_fault;
    sb_acc_e          w_acc;
    logic             w_st;
    logic [31:0]      w_ram_d;
    logic [31:0]      w_ram_i;
    logic [31:0]      w_dword;
    logic [31:0]      w_iword;

    assign w_drel = sb_addr - BASE_ADDR;
    assign w_irel = imem_addr - BASE_ADDR;
    assign w_din  = {1'b0, w_drel} < MEM_BYTES;
    assign w_iin  = {1'b0, w_irel} < MEM_BYTES;
    assign w_didx = w_drel[IDX_W+1:2];
    assign w_iidx = w_irel[IDX_W+1:2];
    assign w_off  = sb_addr[1:0];

    always_comb begin
        w_mask_ok = 1'b0;
        unique case (sb_byte_mask)
            SB_SZ_B: w_mask_ok = 1'b1;
            SB_SZ_H: w_mask_ok = ~w_off[0];
            SB_SZ_W: w_mask_ok = (w_off == 2'b00);
            default: w_mask_ok = 1'b0;
        endcase
    end

`ifdef SB_RESP_MMIO_EN
    assign w_mmio_ok = (sb_addr == SB_MMIO_TOHOST)
                     && (sb_byte_mask == SB_SZ_W);
`else
    assign w_mmio_ok = 1'b0;
`endif

    assign w_act   = sb_re | sb_we;
    assign w_fault = w_act
                   & ((sb_re & sb_we)
                   | ~(w_mmio_ok | (w_din & w_mask_ok)));

    always_comb begin
        w_acc = ACC_IDLE;
        if (w_fault) begin
            w_acc = ACC_BAD;
        end else if (sb_re) begin
            w_acc = ACC_LOAD;
        end else if (sb_we) begin
            w_acc = ACC_STORE;
        end
    end

    // tohost stores never enter the write buffer
    assign w_st = (w_acc == ACC_STORE) & ~w_mmio_ok;

    sb_ram #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk       (clk),
        .i_raddr_a (w_iidx),
        .o_rdata_a (w_ram_i),
        .i_raddr_b (w_didx),
        .o_rdata_b (w_ram_d),
        .i_we      (r_wb_valid),
        .i_widx    (r_wb_idx),
        .i_wlanes  (r_wb_lanes),
        .i_wdata   (r_wb_data)
    );

    assign w_dword = (r_wb_valid && r_wb_idx == w_didx)
                   ? lane_merge(w_ram_d, r_wb_data, r_wb_lanes)
                   : w_ram_d;
    assign w_iword = (r_wb_valid && r_wb_idx == w_iidx)
                   ? lane_merge(w_ram_i, r_wb_data, r_wb_lanes)
                   : w_ram_i;

    assign imem_inst = w_iin ? w_iword : SB_NOP;

    always_comb begin
        sb_rdata = '0;
        if (w_acc == ACC_LOAD) begin
`ifdef SB_RESP_MMIO_EN
            if (w_mmio_ok) begin
                sb_rdata = mmio_tohost;
            end else begin
                sb_rdata = load_ext(w_dword, w_off,
                                    sb_byte_mask, sb_un_sign);
            end
`else
            sb_rdata = load_ext(w_dword, w_off,
                                sb_byte_mask, sb_un_sign);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_idx   <= '0;
            r_wb_lanes <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_wb_valid <= w_st;
            if (w_st) begin
                r_wb_idx   <= w_didx;
                r_wb_lanes <= sb_byte_mask << w_off;
                r_wb_data  <= sb_wdata << {w_off, 3'b000};
            end
            r_err <= (w_acc == ACC_BAD);
            if (w_acc == ACC_BAD && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign sb_err     = r_err;
    assign sb_err_cnt = r_err_cnt;

`ifdef SB_RESP_MMIO_EN
    logic [31:0] r_tohost;
    logic        r_mmio_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tohost     <= '0;
            r_mmio_valid <= 1'b0;
        end else begin
            r_mmio_valid <= (w_acc == ACC_STORE) & w_mmio_ok;
            if ((w_acc == ACC_STORE) && w_mmio_ok) begin
                r_tohost <= sb_wdata;
            end
        end
    end

    assign mmio_tohost = r_tohost;
    assign mmio_valid  = r_mmio_valid;
`endif

endmodule
